// File: rtl/fifo_burst_reader.sv
// Burst reader for a showahead FIFO: drains q/empty/usedw/rdreq into a registered
// valid/ready stream framed by last_o. Define FIFO_BURST_READER_STATS_EN for burst counters.
module fifo_burst_reader #(
  parameter int DWIDTH    = 4,
  parameter int AWIDTH    = 7,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [15:0]       bursts_o,
  output logic [15:0]       short_bursts_o
`endif
);

  localparam int UW  = AWIDTH + 1;
  localparam int BLW = $clog2(BURST_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [UW-1:0]  BURST_LEN_U = UW'(BURST_LEN);
  localparam logic [BLW-1:0] BURST_LEN_B = BLW'(BURST_LEN);
  localparam logic [BLW-1:0] BEAT_ONE    = BLW'(1);
  localparam logic [TW-1:0]  TIMEOUT_T   = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TIMER_ONE   = TW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BLW-1:0]     beats_left_q, beats_left_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [DWIDTH-1:0]  data_q;
  logic               valid_q;
  logic               last_q;

  logic accept_s;
  logic pop_s;
  logic full_s;
  logic timeout_s;
  logic start_s;

  assign accept_s  = !valid_q || ready_i;
  assign pop_s     = (state_q == BURST) && !fifo_empty_i && accept_s && !srst_i;
  assign full_s    = (fifo_usedw_i >= BURST_LEN_U);
  assign timeout_s = (timer_q == TIMEOUT_T) && !fifo_empty_i;
  assign start_s   = (state_q == IDLE) && (full_s || timeout_s);

  assign fifo_rdreq_o = pop_s;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign last_o       = last_q;

  // Burst sequencing: idle timer, burst entry and beat countdown.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    timer_d      = timer_q;
    case (state_q)
      IDLE: begin
        if (fifo_empty_i) begin
          timer_d = '0;
        end else if (timer_q != TIMEOUT_T) begin
          timer_d = timer_q + TIMER_ONE;
        end else begin
          timer_d = timer_q;
        end
        // A timeout entry only happens with usedw < BURST_LEN, so the cast cannot truncate.
        if (start_s) begin
          state_d      = BURST;
          timer_d      = '0;
          beats_left_d = full_s ? BURST_LEN_B : BLW'(fifo_usedw_i);
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        timer_d = '0;
        if (pop_s) begin
          beats_left_d = beats_left_q - BEAT_ONE;
          if (beats_left_q == BEAT_ONE) begin
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d      = IDLE;
        beats_left_d = '0;
        timer_d      = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      timer_q      <= timer_d;
    end
  end

  // Output stage: load on pop, drop valid when drained, hold while stalled.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (pop_s) begin
      data_q  <= fifo_q_i;
      valid_q <= 1'b1;
      last_q  <= (beats_left_q == BEAT_ONE);
    end else if (accept_s) begin
      data_q  <= data_q;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_q;
      valid_q <= valid_q;
      last_q  <= last_q;
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] bursts_q;
  logic [15:0] short_bursts_q;

  assign bursts_o       = bursts_q;
  assign short_bursts_o = short_bursts_q;

  // Burst statistics; a short burst is one entered by timeout.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      bursts_q       <= 16'd0;
      short_bursts_q <= 16'd0;
    end else if (start_s) begin
      bursts_q       <= bursts_q + 16'd1;
      short_bursts_q <= full_s ? short_bursts_q : (short_bursts_q + 16'd1);
    end else begin
      bursts_q       <= bursts_q;
      short_bursts_q <= short_bursts_q;
    end
  end
`endif

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side companion for the team's showahead fifo.
- Drains the FIFO through its q/empty/usedw/rdreq interface and presents the data as a registered valid/ready stream.
- Groups beats into bursts framed by last_o. A burst starts when BURST_LEN words are available, or when a non-empty FIFO has waited TIMEOUT cycles.
- Sits between the FIFO and downstream consumers (DMA or packet sink).

Parameters:
- DWIDTH, 4, data width; must match the FIFO.
- AWIDTH, 7, FIFO address width; usedw is AWIDTH+1 bits.
- BURST_LEN, 8, maximum beats per burst; 1 <= BURST_LEN <= 2**AWIDTH.
- TIMEOUT, 16, idle cycles with data pending before a short burst is forced; >= 1.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- fifo_q_i  in  DWIDTH  FIFO head word; valid whenever fifo_empty_i=0 (showahead).
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_usedw_i  in  AWIDTH+1  FIFO fill level.
- fifo_rdreq_o  out  1  pop request to the FIFO; combinational.
- data_o  out  DWIDTH  stream data, registered.
- valid_o  out  1  stream valid, registered.
- last_o  out  1  final beat of the burst, registered; qualified by valid_o.
- ready_i  in  1  downstream ready.

Behaviour:
- Reset:
  - valid_o=0, last_o=0, data_o=0; state=IDLE; beat and timer counters cleared.
  - fifo_rdreq_o=0 while srst_i=1.
  - Reset mid-burst abandons the burst; no last_o is emitted for it.
  - The FIFO contents are untouched; the reader has no FIFO reset output.
- Output register:
  - Transfer occurs when valid_o && ready_i.
  - While valid_o=1 and ready_i=0, data_o, last_o and valid_o hold unchanged.
  - accept = !valid_o || ready_i.
- Pop rule:
  - fifo_rdreq_o = (state==BURST) && !fifo_empty_i && accept && !srst_i.
  - Never pops an empty FIFO.
  - On a pop, the output register loads data_o=fifo_q_i and valid_o=1 on the next edge.
  - last_o=1 when beats_left==1.
  - When accept=1 and there is no pop, valid_o<=0.
- Latency: one cycle from pop to valid_o. Sustained throughput is 1 beat/cycle with ready_i held at 1.
- IDLE state:
  - timer increments each cycle fifo_empty_i=0, saturating at TIMEOUT.
  - timer clears when fifo_empty_i=1 or on leaving IDLE.
  - Go to BURST when fifo_usedw_i >= BURST_LEN, or when timer==TIMEOUT and fifo_empty_i=0.
  - On entry, beats_left <= min(fifo_usedw_i, BURST_LEN). The full-burst condition has priority; the latched value is identical either way.
- BURST state:
  - beats_left decrements on each pop.
  - The pop with beats_left==1 returns the state to IDLE on the same edge.
  - A new burst may start the following cycle; its pops remain gated by accept.
- Counter widths:
  - beats_left: clog2(BURST_LEN+1) bits.
  - timer: clog2(TIMEOUT+1) bits.
  - The comparison with fifo_usedw_i is done at AWIDTH+1 bits.
- Consistency: this block is the sole reader, so usedw cannot fall below beats_left during a burst. The empty gating is kept as a safety measure. A burst never emits more beats than latched.
- Boundaries:
  - FIFO full (usedw=2**AWIDTH) gives a normal BURST_LEN burst.
  - BURST_LEN=1 gives last_o=1 on every beat.
  - Writes arriving during a burst do not extend it.
  - ready_i low on the last beat holds last_o=1 until accepted.

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- Defined: adds outputs bursts_o[15:0] and short_bursts_o[15:0].
  - bursts_o counts every burst entry.
  - short_bursts_o counts entries where the latched length was < BURST_LEN.
  - Both wrap modulo 2**16 and reset to 0 on srst_i.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- FIFO preloaded with 8 words 0..7 (DWIDTH=4), ready_i=1 -> pops on 8 consecutive cycles; data_o=0..7 on consecutive cycles starting one cycle after the first pop; last_o=1 only with data 7; valid_o=0 afterwards.
- 3 words written, then idle, ready_i=1 -> no pop for the first 16 cycles with FIFO non-empty; a 3-beat burst follows, with last_o on the 3rd beat; short_bursts_o=1 when the macro is enabled.
- 20 words preloaded, ready_i=1 -> bursts of 8, 8, then a timeout burst of 4; last_o asserted on beats 8, 16 and 20.
- 8 words preloaded, ready_i toggling 1/0 each cycle -> data_o and last_o stable while stalled; no FIFO pop while valid_o=1 and ready_i=0; order 0..7 preserved; no word lost or duplicated.
- srst_i asserted for 1 cycle after 3 beats of an 8-beat burst -> next cycle valid_o=0, last_o=0, state=IDLE; FIFO still holds 5 words; with no further writes, a 5-beat burst starts 16 cycles after reset deasserts (timeout), with last_o on its 5th beat.
- Empty FIFO for 100 cycles -> fifo_rdreq_o never asserted; valid_o=0 throughout.
